// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer link stages: line state encoding and
// default word parameters.
package serdes_pkg;

  localparam int         DEF_WIDTH     = 8;
  localparam logic [7:0] DEF_IDLE_WORD = 8'hBC;

  typedef enum logic {
    TRAIN = 1'b0,
    RUN   = 1'b1
  } ser_state_e;

endpackage

// File: rtl/fifo_serializer_if.sv
// FIFO-side pop handshake plus the serial line outputs of the serializer.
interface fifo_serializer_if
  import serdes_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] DATA_IN;
  logic             Valid;
  logic             EMPTY;
  logic             READ;
  logic             DATA_OUT;
  logic             SYNC;
  logic             K_FLAG;
  logic             ERR;

  modport slave (
    input  DATA_IN, Valid, EMPTY,
    output READ, DATA_OUT, SYNC, K_FLAG, ERR
  );

  modport master (
    output DATA_IN, Valid, EMPTY,
    input  READ, DATA_OUT, SYNC, K_FLAG, ERR
  );

endinterface

// File: rtl/fifo_serializer_shift.sv
// Bit counter and MSB-first shift register; loads a new word (with its kind)
// on each word boundary and flags the first bit slot of every word.
module fifo_serializer_shift
  import serdes_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(DEF_IDLE_WORD)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             load_idle,
  output logic             boundary,
  output logic             data_out,
  output logic             sync,
  output logic             k_flag
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic             sync_q;
  logic             k_flag_q;

  assign boundary = (bit_cnt_q == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt_q <= '0;
      sreg_q    <= IDLE_WORD;
      sync_q    <= 1'b1;
      k_flag_q  <= 1'b1;
    end else begin
      bit_cnt_q <= boundary ? '0 : bit_cnt_q + CW'(1);
      // The word after a boundary starts at bit slot 0, hence SYNC follows it.
      sync_q    <= boundary;
      if (load) begin
        sreg_q   <= load_word;
        k_flag_q <= load_idle;
      end else begin
        sreg_q   <= {sreg_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign data_out = sreg_q[WIDTH-1];
  assign sync     = sync_q;
  assign k_flag   = k_flag_q;

endmodule

// File: rtl/fifo_serializer.sv
// Pops bytes from an upstream FIFO and serializes them MSB-first, filling gaps
// with an idle word and sending an idle training preamble after reset.
module fifo_serializer
  import serdes_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(DEF_IDLE_WORD),
  parameter int               PREAMBLE  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  fifo_serializer_if.slave  bus
);

  ser_state_e       state_q, state_d;
  logic [7:0]       train_cnt_q, train_cnt_d;
  logic             read_q, read_d;
  logic             rd_pending_q;
  logic             hold_valid_q;
  logic [WIDTH-1:0] hold_q;
  logic             err_q;

  logic             boundary;
  logic             valid_ok;
  logic             capture;
  logic [WIDTH-1:0] load_word;
  logic             load_idle;

  // Only a Valid answering our own read into an empty hold is real data.
  assign valid_ok = bus.Valid && rd_pending_q && !hold_valid_q;
  assign capture  = valid_ok && !boundary;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    load_word = IDLE_WORD;
    load_idle = 1'b1;
    if (hold_valid_q) begin
      load_word = hold_q;
      load_idle = 1'b0;
    end else if (valid_ok) begin
      load_word = bus.DATA_IN;
      load_idle = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    unique case (state_q)
      TRAIN: begin
        if (boundary) begin
          train_cnt_d = train_cnt_q + 8'd1;
          if (train_cnt_q == 8'(PREAMBLE - 1)) state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
    endcase
  end

  assign read_d = (state_q == RUN) && !bus.EMPTY && !hold_valid_q &&
                  !rd_pending_q && !read_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= TRAIN;
      train_cnt_q  <= '0;
      read_q       <= 1'b0;
      rd_pending_q <= 1'b0;
      hold_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      read_q      <= read_d;
      if (read_d)         rd_pending_q <= 1'b1;
      else if (bus.Valid) rd_pending_q <= 1'b0;
      if (boundary && hold_valid_q) hold_valid_q <= 1'b0;
      else if (capture)             hold_valid_q <= 1'b1;
      if (bus.Valid && (!rd_pending_q || hold_valid_q)) err_q <= 1'b1;
    end
  end

  // NOTE: the hold data register carries no reset; hold_valid_q qualifies it.
  always_ff @(posedge CLK) begin
    if (capture) hold_q <= bus.DATA_IN;
  end

  fifo_serializer_shift #(
    .WIDTH     (WIDTH),
    .IDLE_WORD (IDLE_WORD)
  ) u_shift (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (boundary),
    .load_word (load_word),
    .load_idle (load_idle),
    .boundary  (boundary),
    .data_out  (bus.DATA_OUT),
    .sync      (bus.SYNC),
    .k_flag    (bus.K_FLAG)
  );

  assign bus.READ = read_q;
  assign bus.ERR  = err_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Self-checking bench: FIFO model with a word-slot scoreboard, a cycle table
// for the preamble/first-read timing, and hand sequences for corner cases.
module tb_fifo_serializer;
  import serdes_pkg::*;

  localparam int         W    = 8;
  localparam logic [7:0] IDLE = 8'hBC;
  localparam int         PRE  = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  fifo_serializer_if #(.WIDTH(W)) bus ();

  fifo_serializer #(
    .WIDTH     (W),
    .IDLE_WORD (IDLE),
    .PREAMBLE  (PRE)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         start;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    int   cyc;
    logic sync;
    logic dout;
    logic k;
    logic read;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         data_starts[$];
  vec_t       vecs[16];

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  int         read_cnt = 0;
  int         last_read_cyc = -1;
  logic       prev_read = 1'b0;
  logic       inject = 1'b0;
  logic [7:0] inj_data = 8'h00;
  logic       exp_err = 1'b0;
  logic       exp_err_next = 1'b0;
  logic [7:0] word_acc = 8'h00;
  logic [7:0] exp_word = 8'h00;
  logic       exp_k = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock: advance the cycle count, answer the FIFO handshake, then check
  // the line against the word-slot scoreboard.
  task automatic tick();
    logic rst_seen;
    exp_t e;
    logic [7:0] d;
    rst_seen = RESET;
    @(posedge CLK);
    #1;
    if (rst_seen) begin
      cyc          = 0;
      exp_err      = 1'b0;
      exp_err_next = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      exp_err      = exp_err | exp_err_next;
      exp_err_next = 1'b0;
    end

    if (prev_read) begin
      if (fifo_q.size() == 0) begin
        check("read_on_empty", 1, 0);
        d = 8'h00;
      end else begin
        d = fifo_q.pop_front();
      end
      bus.Valid   = 1'b1;
      bus.DATA_IN = d;
      // A read issued before a reset edge is forgotten by the DUT.
      if (rst_seen) exp_err_next = 1'b1;
      else          exp_q.push_back('{start: (cyc / W + 1) * W, data: d});
    end else if (inject) begin
      bus.Valid    = 1'b1;
      bus.DATA_IN  = inj_data;
      exp_err_next = 1'b1;
      inject       = 1'b0;
    end else begin
      bus.Valid   = 1'b0;
      bus.DATA_IN = 8'h00;
    end
    bus.EMPTY = (fifo_q.size() == 0);

    check("sync", bus.SYNC, (cyc % W) == 0);
    check("err", bus.ERR, exp_err);
    if ((cyc % W) == 0) begin
      if (exp_q.size() > 0 && exp_q[0].start == cyc) begin
        e        = exp_q.pop_front();
        exp_word = e.data;
        exp_k    = 1'b0;
      end else begin
        exp_word = IDLE;
        exp_k    = 1'b1;
      end
      if (bus.K_FLAG === 1'b0) data_starts.push_back(cyc);
    end
    check("k_flag", bus.K_FLAG, exp_k);
    word_acc = {word_acc[6:0], bus.DATA_OUT};
    if ((cyc % W) == W - 1) check("word", word_acc, exp_word);
    if (bus.READ === 1'b1) begin
      read_cnt++;
      last_read_cyc = cyc;
    end
    prev_read = (bus.READ === 1'b1);
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    repeat (n) tick();
    RESET = 1'b0;
    read_cnt      = 0;
    last_read_cyc = -1;
    data_starts.delete();
  endtask

  task automatic run_to(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 500) begin
      tick();
      g++;
    end
    check("run_to", cyc, target);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    bus.EMPTY = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.Valid   = 1'b0;
    bus.EMPTY   = 1'b1;
    bus.DATA_IN = 8'h00;

    // Preamble and first data word timing with 8'hA5 preloaded.
    vecs[0]  = '{0,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{7,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{31, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{32, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{33, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{34, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{40, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{41, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{42, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{43, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{44, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{45, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{46, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{47, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{48, 1'b1, 1'b1, 1'b1, 1'b0};

    // 1: empty FIFO, idle pattern only.
    do_reset(2);
    check("t1_rst_dout", bus.DATA_OUT, 1'b1);
    repeat (100) tick();
    check("t1_no_read", read_cnt, 0);

    // 2: preamble then first data word.
    push_byte(8'hA5);
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      run_to(vecs[i].cyc);
      check("t2_sync", bus.SYNC, vecs[i].sync);
      check("t2_dout", bus.DATA_OUT, vecs[i].dout);
      check("t2_k", bus.K_FLAG, vecs[i].k);
      check("t2_read", bus.READ, vecs[i].read);
    end
    check("t2_read_cnt", read_cnt, 1);
    check("t2_read_cyc", last_read_cyc, 33);

    // 3: back-to-back data words.
    data_starts.delete();
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    repeat (40) tick();
    check("t3_words", data_starts.size(), 3);
    if (data_starts.size() == 3) begin
      check("t3_first", data_starts[0], 56);
      check("t3_gap01", data_starts[1] - data_starts[0], W);
      check("t3_gap12", data_starts[2] - data_starts[1], W);
    end

    // 4: unsolicited Valid sets sticky ERR, line stays idle.
    inj_data = 8'h77;
    inject   = 1'b1;
    tick();
    tick();
    check("t4_err_set", bus.ERR, 1'b1);
    repeat (20) tick();
    check("t4_err_sticky", bus.ERR, 1'b1);

    // 5: Valid exactly on a boundary bypasses hold.
    do_reset(2);
    check("t5_err_clr", bus.ERR, 1'b0);
    g = 0;
    while (!(cyc >= 40 && (cyc % W) == 5) && g < 100) begin
      tick();
      g++;
    end
    check("t5_align", cyc % W, 5);
    push_byte(8'hC3);
    tick();
    check("t5_read", bus.READ, 1'b1);
    tick();
    check("t5_valid_at_bnd", cyc % W, W - 1);
    tick();
    check("t5_hold_empty", dut.hold_valid_q, 1'b0);
    check("t5_k_data", bus.K_FLAG, 1'b0);
    repeat (8) tick();
    check("t5_one_word", data_starts.size(), 1);

    // 6: reset mid data word with a read outstanding.
    push_byte(8'h5A);
    do_reset(2);
    run_to(42);
    push_byte(8'h3C);
    tick();
    check("t6_read_out", bus.READ, 1'b1);
    check("t6_bit3", cyc % W, 3);
    do_reset(1);
    check("t6_rst_sync", bus.SYNC, 1'b1);
    check("t6_rst_dout", bus.DATA_OUT, 1'b1);
    check("t6_rst_k", bus.K_FLAG, 1'b1);
    check("t6_rst_read", bus.READ, 1'b0);
    check("t6_rst_err", bus.ERR, 1'b0);
    push_byte(8'h96);
    tick();
    check("t6_late_err", bus.ERR, 1'b1);
    run_to(48);
    check("t6_read_cnt", read_cnt, 1);
    check("t6_read_cyc", last_read_cyc, 33);
    check("t6_words", data_starts.size(), 1);
    if (data_starts.size() == 1) check("t6_start", data_starts[0], 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
